// File: rtl/sa_pkg.sv
`default_nettype none
// sa_pkg: state encoding and step-count helper shared by the systolic feeder files.
package sa_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    CLEAR   = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } sa_state_t;

  function automatic int sa_steps(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_skew_buf.sv
`default_nettype none
// sa_skew_buf: DIMxDIM operand store with a combinational diagonal (skewed) read for step t.
module sa_skew_buf
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int IDX_W   = $clog2(DIM),
  parameter int STEP_W  = $clog2(3 * DIM - 2)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DIM-1:0][BITS_AB-1:0]  wr_a,
  input  logic [DIM-1:0][BITS_AB-1:0]  wr_b,
  input  logic                         active,
  input  logic [STEP_W-1:0]            step,
  output logic [DIM-1:0][BITS_AB-1:0]  sel_a,
  output logic [DIM-1:0][BITS_AB-1:0]  sel_b
);

  // a_mem[k][r] = A[r][k], b_mem[k][c] = B[k][c]
  logic [DIM-1:0][BITS_AB-1:0] a_mem [DIM];
  logic [DIM-1:0][BITS_AB-1:0] b_mem [DIM];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[wr_idx] <= wr_a;
      b_mem[wr_idx] <= wr_b;
    end
  end

  // Edge lane i carries element k = t - i; outside the diagonal band it is zero.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < DIM; i++) begin
      if (active && (int'(step) >= i) && (int'(step) - i < DIM)) begin
        sel_a[i] = a_mem[IDX_W'(int'(step) - i)][i];
        sel_b[i] = b_mem[IDX_W'(int'(step) - i)][i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// systolic_feeder: loads an operand pair, clears, feeds skewed wavefronts and drains result rows.
// Optional macro SA_ACCUM_EN adds an accum input that skips CLEAR for K-tiling.
module systolic_feeder
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]   in_a,
  input  logic [DIM-1:0][BITS_AB-1:0]   in_b,
`ifdef SA_ACCUM_EN
  input  logic                          accum,
`endif
  output logic [DIM-1:0][BITS_AB-1:0]   arr_a,
  output logic [DIM-1:0][BITS_AB-1:0]   arr_b,
  output logic                          arr_en,
  output logic                          arr_wren,
  output logic [DIM-1:0][BITS_C-1:0]    arr_cin,
  output logic [$clog2(DIM)-1:0]        arr_crow,
  input  logic [DIM-1:0][BITS_C-1:0]    arr_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIM-1:0][BITS_C-1:0]    out_c,
  output logic [$clog2(DIM)-1:0]        out_row,
  output logic                          out_last,
  output logic                          busy
);

  localparam int IDX_W  = $clog2(DIM);
  localparam int STEPS  = sa_steps(DIM);
  localparam int STEP_W = $clog2(STEPS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  sa_state_t          state, state_nx;
  logic [IDX_W-1:0]   cnt;
  logic [IDX_W-1:0]   row;
  logic [STEP_W-1:0]  step;
  logic               in_fire, out_fire, skip_clear;

  assign in_fire  = (state == LOAD) && in_valid;
  assign out_fire = (state == DRAIN) && out_ready;

`ifdef SA_ACCUM_EN
  logic accum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      accum_q <= 1'b0;
    else if (in_fire && (cnt == '0))
      accum_q <= accum;
  end
  // The flag belongs to the job's first beat, which may also be its last.
  assign skip_clear = (cnt == '0) ? accum : accum_q;
`else
  assign skip_clear = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      step  <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD:    if (in_fire) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        CLEAR:   cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        COMPUTE: step <= (step == LAST_STEP) ? '0 : step + 1'b1;
        DRAIN:   if (out_fire) row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    arr_en    = 1'b0;
    arr_wren  = 1'b0;
    arr_crow  = '0;
    out_valid = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && (cnt == LAST_IDX))
          state_nx = skip_clear ? COMPUTE : CLEAR;
      end
      CLEAR: begin
        arr_wren = 1'b1;
        arr_crow = cnt;
        if (cnt == LAST_IDX) state_nx = COMPUTE;
      end
      COMPUTE: begin
        arr_en = 1'b1;
        if (step == LAST_STEP) state_nx = DRAIN;
      end
      DRAIN: begin
        arr_crow  = row;
        out_valid = 1'b1;
        if (out_fire && (row == LAST_IDX)) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  sa_skew_buf #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .IDX_W   (IDX_W),
    .STEP_W  (STEP_W)
  ) u_skew (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_idx (cnt),
    .wr_a   (in_a),
    .wr_b   (in_b),
    .active (state == COMPUTE),
    .step   (step),
    .sel_a  (arr_a),
    .sel_b  (arr_b)
  );

  assign arr_cin  = '0;
  assign out_c    = arr_cout;
  assign out_row  = row;
  assign out_last = (state == DRAIN) && (row == LAST_IDX);
  assign busy     = (state != LOAD);

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// tb_systolic_feeder: scoreboard bench with a behavioural output-stationary MAC array model.
module tb_systolic_feeder;

  localparam int DIM = 8;
  localparam int BA  = 8;
  localparam int BC  = 16;
  localparam int IW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  in_valid, in_ready, arr_en, arr_wren, out_valid, out_ready, out_last, busy;
  logic [DIM-1:0][BA-1:0] in_a, in_b, arr_a, arr_b;
  logic [DIM-1:0][BC-1:0] arr_cin, arr_cout, out_c;
  logic [IW-1:0]          arr_crow, out_row;
`ifdef SA_ACCUM_EN
  logic                   accum;
`endif

  systolic_feeder #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef SA_ACCUM_EN
    .accum(accum),
`endif
    .arr_a(arr_a), .arr_b(arr_b), .arr_en(arr_en), .arr_wren(arr_wren), .arr_cin(arr_cin),
    .arr_crow(arr_crow), .arr_cout(arr_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  // Array model: A flows right, B flows down, each PE accumulates a*b while en is high.
  logic signed [BC-1:0] acc [DIM][DIM];
  logic signed [BA-1:0] ap  [DIM][DIM];
  logic signed [BA-1:0] bp  [DIM][DIM];

  function automatic logic signed [BA-1:0] a_in(input int r, input int c);
    if (c == 0) return arr_a[r];
    return ap[r][c-1];
  endfunction
  function automatic logic signed [BA-1:0] b_in(input int r, input int c);
    if (r == 0) return arr_b[c];
    return bp[r-1][c];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          acc[r][c] <= '0; ap[r][c] <= '0; bp[r][c] <= '0;
        end
    end else begin
      if (arr_wren)
        for (int c = 0; c < DIM; c++) acc[arr_crow][c] <= arr_cin[c];
      if (arr_en)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++) begin
            acc[r][c] <= acc[r][c] + a_in(r, c) * b_in(r, c);
            ap[r][c]  <= a_in(r, c);
            bp[r][c]  <= b_in(r, c);
          end
    end
  end

  always_comb begin
    arr_cout = '0;
    for (int c = 0; c < DIM; c++) arr_cout[c] = acc[arr_crow][c];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DIM*BC-1:0] c;
    int                row;
    bit                last;
  } exp_t;
  exp_t q[$];

  int ma [DIM][DIM];
  int mb [DIM][DIM];

  // amode: 0 A=I, 1 A=-I, 2 A=B=127; otherwise B[k][c] = 8k+c
  task automatic set_mats(input int amode);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        if (amode == 2) begin
          ma[i][j] = 127; mb[i][j] = 127;
        end else begin
          ma[i][j] = (i == j) ? ((amode == 1) ? -1 : 1) : 0;
          mb[i][j] = 8 * i + j;
        end
      end
  endtask

  // emode: 0 C=B, 1 C=-B, 2 C=-2040 (129032 wrapped), 3 C=2B
  function automatic logic [DIM*BC-1:0] exp_row(input int emode, input int r);
    logic [DIM*BC-1:0] e;
    int v;
    e = '0;
    for (int c = 0; c < DIM; c++) begin
      case (emode)
        0:       v = 8 * r + c;
        1:       v = -(8 * r + c);
        2:       v = -2040;
        default: v = 2 * (8 * r + c);
      endcase
      e[c*BC +: BC] = BC'(v);
    end
    return e;
  endfunction

  task automatic push_exp(input int emode);
    exp_t e;
    for (int r = 0; r < DIM; r++) begin
      e.c = exp_row(emode, r); e.row = r; e.last = (r == DIM - 1);
      q.push_back(e);
    end
  endtask

  task automatic load_job(input int amode, input bit bubbles, input bit acc_v);
    int guard;
    set_mats(amode);
    for (int k = 0; k < DIM; k++) begin
      @(negedge clk);
      if (bubbles && (k % 3 == 1)) @(negedge clk);
      for (int r = 0; r < DIM; r++) in_a[r] = BA'(ma[r][k]);
      for (int c = 0; c < DIM; c++) in_b[c] = BA'(mb[k][c]);
`ifdef SA_ACCUM_EN
      accum = acc_v;
`endif
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
      if (guard >= 500) chk("load_timeout", 1, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((q.size() != 0 || busy) && guard < 3000) begin @(negedge clk); guard++; end
    chk("job_done_timeout", guard >= 3000, 0);
  endtask

  // Monitor: latency, scoreboard pops, stall stability, in_ready after the last row.
  int   last_beat = 0;
  bit   lat_pending = 0;
  int   exp_lat = 0;
  bit   stalled = 0;
  bit   chk_ready = 0;
  int   wren_seen = 0;
  logic [DIM*BC-1:0] held_c;
  logic [IW-1:0]     held_row;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      if (arr_wren) wren_seen++;
      if (chk_ready) begin
        chk("in_ready_after_last", in_ready, 1);
        chk_ready = 0;
      end
      if (in_valid && in_ready) begin last_beat = cyc; lat_pending = 1; end
      if (out_valid) begin
        if (lat_pending && exp_lat != 0) chk("first_valid_latency", cyc - last_beat, exp_lat);
        lat_pending = 0;
        if (stalled) begin
          chk("stall_c_stable", out_c, held_c);
          chk("stall_row_stable", out_row, held_row);
        end
        if (out_ready) begin
          stalled = 0;
          if (q.size() == 0) chk("unexpected_row", {1'b1, out_row}, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("row%0d_c", e.row), out_c, e.c);
            chk($sformatf("row%0d_idx", e.row), out_row, e.row);
            chk($sformatf("row%0d_last", e.row), out_last, e.last);
            if (out_last) chk_ready = 1;
          end
        end else begin
          stalled = 1; held_c = out_c; held_row = out_row;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DIM*BA-1:0] ea, eb;
    int guard;
    in_valid = 0; out_ready = 1; in_a = '0; in_b = '0;
`ifdef SA_ACCUM_EN
    accum = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_arr_wren", arr_wren, 0);
    chk("rst_arr_crow", arr_crow, 0);
    chk("rst_arr_ab", {arr_a, arr_b}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Identity job, plus CLEAR runs exactly DIM cycles
    exp_lat = 31; wren_seen = 0;
    push_exp(0); load_job(0, 0, 0); wait_done();
    chk("clear_cycles", wren_seen, DIM);

    // Overflow wrap, with in_valid junk while busy
    push_exp(2); load_job(2, 0, 0);
    in_a = '1; in_b = '1; in_valid = 1;
    repeat (20) @(posedge clk);
    #1 in_valid = 0;
    wait_done();

    // Backpressure at row 3
    push_exp(0); load_job(0, 0, 0);
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!(out_valid && out_row == 3) && guard < 200);
    chk("bp_reach_row3", guard >= 200, 0);
    out_ready = 0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    wait_done();

    // Back-to-back: I then -I with same B
    push_exp(0); load_job(0, 0, 0);
    push_exp(1); load_job(1, 0, 0);
    wait_done();

    // Reset at COMPUTE step 10
    exp_lat = 0;
    load_job(0, 0, 0);
    guard = 0;
    while (!arr_en && guard < 200) begin @(posedge clk); #1; guard++; end
    repeat (10) @(posedge clk);
    #1;
    ea = '0; eb = '0;
    ea[5*BA +: BA] = 8'd1;
    for (int c = 3; c < DIM; c++) eb[c*BA +: BA] = BA'(8 * (10 - c) + c);
    chk("t10_arr_en", arr_en, 1);
    chk("t10_arr_a", arr_a, ea);
    chk("t10_arr_b", arr_b, eb);
    rst = 1;
    #1;
    chk("abort_arr_en", arr_en, 0);
    chk("abort_arr_ab", {arr_a, arr_b}, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1 rst = 0;

    // Identity job loaded with bubbles after the abort
    exp_lat = 31;
    push_exp(0); load_job(0, 1, 0); wait_done();

`ifdef SA_ACCUM_EN
    push_exp(0); load_job(0, 0, 0); wait_done();
    @(posedge clk); #1 wren_seen = 0;
    exp_lat = 23;
    push_exp(3); load_job(0, 0, 1); wait_done();
    chk("accum_no_clear", wren_seen, 0);
    accum = 0;
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Sequencer that drives the systolic MAC array from the operand side and drains its result side.
- Accepts one DIM×DIM matrix pair as DIM handshaked beats and clears the array accumulators.
- Issues diagonally skewed A/B wavefronts with en asserted, then streams the DIM result rows out over a valid/ready port by stepping Crow.
- Sits between the host/AFU data path and the array instance.

Parameters:
BITS_AB, 8, signed operand width
BITS_C, 16, signed accumulator/result width
DIM, 8, array dimension (rows = cols = K)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  asynchronous, active-high reset
in_valid  in  1  load beat valid
in_ready  out  1  high only in LOAD
in_a  in  DIM×BITS_AB signed  beat k: column k of A (in_a[r] = A[r][k])
in_b  in  DIM×BITS_AB signed  beat k: row k of B (in_b[c] = B[k][c])
arr_a  out  DIM×BITS_AB signed  to array A (row r edge)
arr_b  out  DIM×BITS_AB signed  to array B (column c edge)
arr_en  out  1  array MAC/shift enable
arr_wren  out  1  array accumulator write enable
arr_cin  out  DIM×BITS_C signed  array write data, always 0
arr_crow  out  $clog2(DIM)  array row select (write and read)
arr_cout  in  DIM×BITS_C signed  array row read data for arr_crow
out_valid  out  1  result row valid
out_ready  in  1  result row accepted
out_c  out  DIM×BITS_C signed  result row, C[out_row][*]
out_row  out  $clog2(DIM)  row index
out_last  out  1  high with row DIM-1
busy  out  1  state != LOAD

Behaviour:
Reset:
- state = LOAD; beat, step and row counters = 0; operand buffer not cleared.
- arr_en, arr_wren, out_valid, busy = 0.
- arr_a, arr_b, arr_crow = 0.
- in_ready = 1 once reset deasserts.

States:
- LOAD:
  - in_ready = 1. Each in_valid&in_ready stores in_a/in_b at buffer index k, then k++.
  - Bubbles are allowed.
  - When k = DIM-1 is accepted, go to CLEAR.
- CLEAR: DIM cycles. arr_wren = 1, arr_crow = clear counter 0..DIM-1, arr_cin = 0, arr_en = 0. Then go to COMPUTE.
- COMPUTE: 3·DIM-2 cycles, step t = 0..3·DIM-3, arr_en = 1.
  - arr_a[r] = A[r][t-r] when 0 ≤ t-r < DIM, else 0.
  - arr_b[c] = B[t-c][c] when 0 ≤ t-c < DIM, else 0.
  - After the last step, go to DRAIN.
  - arr_a/arr_b outside COMPUTE are 0.
- DRAIN:
  - arr_en = 0, so the array holds its results.
  - arr_crow = out_row. out_c = arr_cout, combinational with zero latency. out_valid = 1.
  - Advance out_row on out_valid&out_ready. out_c and out_row are held stable while out_ready is low.
  - Handshake with out_last: return to LOAD, so in_ready is high the next cycle.

Latency and arithmetic:
- The last load beat accepted at cycle N gives first out_valid at cycle N + 4·DIM - 1 (31 for DIM = 8).
- Array arithmetic wraps mod 2^BITS_C; the feeder performs no saturation.

Boundary conditions:
- in_valid outside LOAD is ignored.
- out_ready held low stalls DRAIN indefinitely with no loss.
- rst asserted mid-operation aborts immediately to the reset state. The next job's CLEAR erases partial sums.
- The beat counter wraps only through the state transition and never indexes beyond DIM-1.

Optional Feature:
SA_ACCUM_EN
- Defined:
  - Adds input port accum (1 bit), sampled on the first accepted beat of a job.
  - accum = 1 skips CLEAR (LOAD → COMPUTE directly), so results accumulate onto the prior C for K-tiling.
  - Latency becomes N + 3·DIM - 1.
- Undefined: no accum port; CLEAR always runs.

Decomposition:
- Package sa_pkg:
  - sa_state_t enum {LOAD, CLEAR, COMPUTE, DRAIN}.
  - Helper function sa_steps(dim) = 3·dim-2.
  - Width typedefs are not included; they stay parameterized.
- Sub-module sa_skew_buf:
  - DIM×DIM A and B storage plus write port.
  - Combinational diagonal select from step t, with zero fill.
- systolic_feeder keeps the FSM, counters and handshakes.

Test Plan:
- Identity: A = I, B[k][c] = 8k+c (DIM = 8) → rows 0..7 equal B rows; out_row 0..7; out_last only on row 7; first out_valid 31 cycles after the last beat.
- Overflow wrap: all A = B = 127 → every C element = 129032 mod 2^16 = -2040 signed.
- Backpressure: out_ready low for 5 cycles at row 3 → out_c and out_row stable; all 8 rows delivered once, in order.
- Back-to-back: job 1 as in test 1, then job 2 with A = -I, same B → job 2 rows = -B (CLEAR verified); in_ready high the cycle after the row-7 handshake.
- Reset mid-COMPUTE at t = 10 → next cycle arr_en = 0, arr_a/arr_b = 0, in_ready = 1; a following identity job is correct. Load with in_valid bubbles → identical results.
- SA_ACCUM_EN: identity job, then the same job with accum = 1 → C = 2·B; CLEAR cycles absent (arr_wren never high during job 2).
